// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-0 SPI controller.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_e;

  localparam int DATA_W_DEF = 128;
  localparam bit CPOL       = 1'b0;
  localparam bit CPHA       = 1'b0;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period down-counter producing sclk plus one-cycle rise/fall strobes.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic run_i,
  output logic sclk_o,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(HALF + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  assign tick_o = en_i && (cnt_q == '0);
  assign rise_o = tick_o && run_i && !sclk_q;
  assign fall_o = tick_o && run_i && sclk_q;
  assign sclk_o = sclk_q ^ CPOL;

  // Idle load is one count longer so the first enabled cycle absorbs the start-edge register.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = 1'b0;
    if (!en_i) begin
      cnt_d = CW'(HALF);
    end else if (tick_o) begin
      cnt_d = CW'(HALF - 1);
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
    if (en_i) begin
      sclk_d = sclk_q ^ (tick_o && run_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= CW'(HALF);
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_main.sv
// Mode-0 SPI controller: one full-duplex DATA_W-bit frame per start rising edge.
// Define SPI_LSB_FIRST_EN to shift tx out LSB first (default MSB first).
module spi_main
  import spi_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_i,
  input  logic              miso_i,
  output logic [DATA_W-1:0] rx_o,
  output logic              cs_n_o,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              done_o
);

  localparam int BW = $clog2(DATA_W + 1);

  spi_state_e        state_q, state_d;
  logic              start_q;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic              tick, rise, fall, smp, drv;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q != IDLE),
    .run_i  (state_q == SHIFT),
    .sclk_o (sclk_o),
    .tick_o (tick),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign smp = (CPHA == 1'b0) ? rise : fall;
  assign drv = (CPHA == 1'b0) ? fall : rise;

  always_comb begin
    state_d = state_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !start_q) begin
          state_d = SETUP;
          tx_sh_d = tx_i;
          cs_n_d  = 1'b0;
          bit_d   = BW'(DATA_W);
`ifdef SPI_LSB_FIRST_EN
          mosi_d  = tx_i[0];
`else
          mosi_d  = tx_i[DATA_W-1];
`endif
        end
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (smp) begin
          rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_i};
          bit_d   = bit_q - BW'(1);
        end
        if (drv) begin
`ifdef SPI_LSB_FIRST_EN
          tx_sh_d = tx_sh_q >> 1;
          mosi_d  = tx_sh_q[1];
`else
          tx_sh_d = tx_sh_q << 1;
          mosi_d  = tx_sh_q[DATA_W-2];
`endif
          // Falling edge after the last sample closes the shift phase.
          if (bit_q == '0) state_d = HOLD;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          rx_d    = rx_sh_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign rx_o   = rx_q;
  assign cs_n_o = cs_n_q;
  assign mosi_o = mosi_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_spi_main.sv
// Directed bench for spi_main looped back to a behavioural mode-0 sub-node.
`timescale 1ns/100ps
module tb_spi_main;

  logic         clk_i   = 1'b0;
  logic         rst_i   = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] tx_i    = '0;
  logic         miso_i  = 1'b0;
  logic [127:0] rx_o;
  logic         cs_n_o, sclk_o, mosi_o, done_o;

  int vecs = 0;
  int errs = 0;
  int done_cnt = 0;
  int rise_cnt = 0;
  int cs_low_cnt = 0;

  logic [127:0] sub_tx = '0;
  logic [127:0] sub_sh = '0;
  logic [127:0] sub_rx = '0;

  spi_main #(.DATA_W(128), .CLK_DIV(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .tx_i    (tx_i),
    .miso_i  (miso_i),
    .rx_o    (rx_o),
    .cs_n_o  (cs_n_o),
    .sclk_o  (sclk_o),
    .mosi_o  (mosi_o),
    .done_o  (done_o)
  );

  always #1 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (!cs_n_o) cs_low_cnt++;
  end

  always @(posedge sclk_o) rise_cnt++;

  // Sub-node: loads on select, samples on rising sclk, shifts out on falling sclk.
  always @(negedge cs_n_o) begin
    sub_sh = sub_tx;
    miso_i = sub_sh[127];
    sub_rx = '0;
  end

  always @(posedge sclk_o) begin
    if (!cs_n_o) begin
`ifdef SPI_LSB_FIRST_EN
      sub_rx = {mosi_o, sub_rx[127:1]};
`else
      sub_rx = {sub_rx[126:0], mosi_o};
`endif
    end
  end

  always @(negedge sclk_o) begin
    if (!cs_n_o) begin
      sub_sh = sub_sh << 1;
      miso_i = sub_sh[127];
    end
  end

  task automatic run_frame(input logic [127:0] t, input logic [127:0] st, input int hold,
                           input int second_at, output int lat, output logic [127:0] rx_mid,
                           output logic first_mosi);
    int cyc;
    lat = -1;
    cyc = 0;
    rx_mid = 'x;
    first_mosi = 1'bx;
    tx_i = t;
    sub_tx = st;
    @(negedge clk_i);
    start_i = 1'b1;
    while (cyc < 700) begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 1) first_mosi = mosi_o;
      if (cyc == hold) start_i = 1'b0;
      if (second_at > 0 && cyc == second_at) start_i = 1'b1;
      if (second_at > 0 && cyc == second_at + 5) start_i = 1'b0;
      if (cyc == 20) tx_i = ~t;
      if (cyc == 300) rx_mid = rx_o;
      if (done_o && lat < 0) lat = cyc;
      if (lat > 0 && cyc >= lat + 20) break;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_i);
    vecs++; if (cs_n_o !== 1'b1) begin errs++; $display("FAIL reset_cs_n: got %b expected 1", cs_n_o); end
    vecs++; if (sclk_o !== 1'b0) begin errs++; $display("FAIL reset_sclk: got %b expected 0", sclk_o); end
    vecs++; if (mosi_o !== 1'b0) begin errs++; $display("FAIL reset_mosi: got %b expected 0", mosi_o); end
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", done_o); end
    vecs++; if (rx_o !== 128'h0) begin errs++; $display("FAIL reset_rx: got %h expected 0", rx_o); end
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    vecs++; if (cs_n_o !== 1'b1) begin errs++; $display("FAIL idle_cs_n: got %b expected 1", cs_n_o); end
  endtask

  task automatic test_basic_frame;
    int lat, d0, r0;
    logic [127:0] rm;
    logic fm;
    d0 = done_cnt;
    r0 = rise_cnt;
    run_frame(128'h00112233445566778899aabbccddeeff, 128'h0, 10, 0, lat, rm, fm);
    vecs++; if (lat !== 518) begin errs++; $display("FAIL t1_latency: got %0d expected 518", lat); end
    vecs++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL t1_done_count: got %0d expected 1", done_cnt - d0); end
    vecs++; if (rise_cnt - r0 !== 128) begin errs++; $display("FAIL t1_sclk_rises: got %0d expected 128", rise_cnt - r0); end
    vecs++; if (rx_o !== 128'h0) begin errs++; $display("FAIL t1_rx: got %h expected 0", rx_o); end
    vecs++; if (sub_rx !== 128'h00112233445566778899aabbccddeeff) begin
      errs++; $display("FAIL t1_sub_rx: got %h expected 00112233445566778899aabbccddeeff", sub_rx);
    end
    vecs++; if (fm !== 1'b0) begin errs++; $display("FAIL t1_first_mosi: got %b expected 0", fm); end
  endtask

  task automatic test_pattern_55;
    int lat;
    logic [127:0] rm;
    logic fm;
    run_frame(128'h99999999999999999, 128'h555555555555555555, 10, 0, lat, rm, fm);
    vecs++; if (rx_o !== 128'h555555555555555555) begin errs++; $display("FAIL t2_rx: got %h expected 555555555555555555", rx_o); end
    vecs++; if (sub_rx !== 128'h99999999999999999) begin errs++; $display("FAIL t2_sub_rx: got %h expected 99999999999999999", sub_rx); end
    vecs++; if (rm !== 128'h0) begin errs++; $display("FAIL t2_rx_hold_mid: got %h expected 0", rm); end
    vecs++; if (lat !== 518) begin errs++; $display("FAIL t2_latency: got %0d expected 518", lat); end
  endtask

  task automatic test_short_words;
    int lat, c0;
    logic [127:0] rm;
    logic fm;
    c0 = cs_low_cnt;
    run_frame(128'habde1, 128'hfa4d, 3, 0, lat, rm, fm);
    vecs++; if (rx_o !== 128'hfa4d) begin errs++; $display("FAIL t3_rx: got %h expected fa4d", rx_o); end
    vecs++; if (sub_rx !== 128'habde1) begin errs++; $display("FAIL t3_sub_rx: got %h expected abde1", sub_rx); end
    vecs++; if (cs_low_cnt - c0 !== 517) begin errs++; $display("FAIL t3_cs_low_cycles: got %0d expected 517", cs_low_cnt - c0); end
    vecs++; if (cs_n_o !== 1'b1) begin errs++; $display("FAIL t3_cs_after: got %b expected 1", cs_n_o); end
    vecs++; if (rm !== 128'h555555555555555555) begin errs++; $display("FAIL t3_rx_hold_mid: got %h expected 555555555555555555", rm); end
  endtask

  task automatic test_ignored_start;
    int lat, d0, r0;
    logic [127:0] rm;
    logic fm;
    d0 = done_cnt;
    r0 = rise_cnt;
    run_frame(128'h80000000000000000000000000000001, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 10, 100, lat, rm, fm);
    repeat (20) @(negedge clk_i);
    vecs++; if (rise_cnt - r0 !== 128) begin errs++; $display("FAIL t4_sclk_rises: got %0d expected 128", rise_cnt - r0); end
    vecs++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL t4_done_count: got %0d expected 1", done_cnt - d0); end
    vecs++; if (lat !== 518) begin errs++; $display("FAIL t4_latency: got %0d expected 518", lat); end
    vecs++; if (cs_n_o !== 1'b1) begin errs++; $display("FAIL t4_cs_after: got %b expected 1", cs_n_o); end
    vecs++; if (fm !== 1'b1) begin errs++; $display("FAIL t4_first_mosi: got %b expected 1", fm); end
    vecs++; if (rx_o !== 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f) begin
      errs++; $display("FAIL t4_rx: got %h expected 0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f", rx_o);
    end
  endtask

  task automatic test_reset_mid;
    int lat, d0;
    logic [127:0] rm;
    logic fm;
    tx_i = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    sub_tx = 128'h1234;
    d0 = done_cnt;
    @(negedge clk_i);
    start_i = 1'b1;
    repeat (10) @(negedge clk_i);
    start_i = 1'b0;
    repeat (190) @(negedge clk_i);
    vecs++; if (cs_n_o !== 1'b0) begin errs++; $display("FAIL t5_cs_in_frame: got %b expected 0", cs_n_o); end
    rst_i = 1'b1;
    #0.2;
    vecs++; if (cs_n_o !== 1'b1) begin errs++; $display("FAIL t5_cs_on_rst: got %b expected 1", cs_n_o); end
    vecs++; if (sclk_o !== 1'b0) begin errs++; $display("FAIL t5_sclk_on_rst: got %b expected 0", sclk_o); end
    vecs++; if (rx_o !== 128'h0) begin errs++; $display("FAIL t5_rx_on_rst: got %h expected 0", rx_o); end
    vecs++; if (mosi_o !== 1'b0) begin errs++; $display("FAIL t5_mosi_on_rst: got %b expected 0", mosi_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (20) @(negedge clk_i);
    vecs++; if (done_cnt - d0 !== 0) begin errs++; $display("FAIL t5_no_done: got %0d expected 0", done_cnt - d0); end
    run_frame(128'h0123456789abcdef0f1e2d3c4b5a6978, 128'hfedcba98765432100011223344556677, 10, 0, lat, rm, fm);
    vecs++; if (rx_o !== 128'hfedcba98765432100011223344556677) begin
      errs++; $display("FAIL t5_rx_clean: got %h expected fedcba98765432100011223344556677", rx_o);
    end
    vecs++; if (sub_rx !== 128'h0123456789abcdef0f1e2d3c4b5a6978) begin
      errs++; $display("FAIL t5_sub_rx_clean: got %h expected 0123456789abcdef0f1e2d3c4b5a6978", sub_rx);
    end
    vecs++; if (lat !== 518) begin errs++; $display("FAIL t5_latency: got %0d expected 518", lat); end
  endtask

`ifdef SPI_LSB_FIRST_EN
  task automatic test_lsb_first;
    int lat;
    logic [127:0] rm;
    logic fm;
    run_frame(128'h1, 128'h0, 10, 0, lat, rm, fm);
    vecs++; if (fm !== 1'b1) begin errs++; $display("FAIL t6_first_mosi: got %b expected 1", fm); end
    vecs++; if (sub_rx !== 128'h1) begin errs++; $display("FAIL t6_sub_rx: got %h expected 1", sub_rx); end
    vecs++; if (lat !== 518) begin errs++; $display("FAIL t6_latency: got %0d expected 518", lat); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_pattern_55();
    test_short_words();
    test_ignored_start();
    test_reset_mid();
`ifdef SPI_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
